// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two requester ports (fetch "i", data "d"), the
// shared single-port memory bus and the arbiter status outputs.
//   slave  : arbiter side (takes requests and mem_rdata, drives memory bus/done/stall).
//   master : requester/memory side (drives requests and mem_rdata).
interface mem_arbiter_if;
  // Fetch port
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_done;
  logic [15:0] i_rdata;
  logic        i_stall;
  // Data port
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_done;
  logic [15:0] d_rdata;
  logic        d_stall;
  // Shared memory
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  // Status
  logic        busy;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    output i_done, i_rdata, i_stall, d_done, d_rdata, d_stall,
    output mem_en, mem_wr, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    input  i_done, i_rdata, i_stall, d_done, d_rdata, d_stall,
    input  mem_en, mem_wr, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter giving a fetch port (i) and a data port (d)
// access to one shared single-port memory with a fixed latency of LAT cycles.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mem_arbiter_if.slave - requests, memory bus, done/rdata/stall, busy
// A grant happens in an IDLE cycle, BUSY lasts LAT cycles, and the owner's
// done pulse lands in the following (IDLE) cycle, where the other port may be
// granted immediately.
module mem_arbiter #(
  parameter int unsigned LAT = 2  // legal range 1..7
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic {StIdle, StBusy} state_e;
  typedef enum logic {OwnI = 1'b0, OwnD = 1'b1} owner_e;

  localparam logic [2:0] CntLoad = 3'(LAT - 1);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  owner_e      last_owner_q, last_owner_d;
  owner_e      grant;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        i_done_q, i_done_d;
  logic        d_done_q, d_done_d;
  logic [15:0] i_rdata_q, i_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        i_elig, d_elig;

  // A port whose done is high is still holding req for the finished access.
  assign i_elig = bus.i_req & ~i_done_q;
  assign d_elig = bus.d_req & ~d_done_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    grant        = OwnI;

    if (i_elig && d_elig) begin
      grant = (last_owner_q == OwnI) ? OwnD : OwnI;
    end else if (d_elig) begin
      grant = OwnD;
    end

    unique case (state_q)
      StIdle: begin
        if (i_elig || d_elig) begin
          state_d      = StBusy;
          owner_d      = grant;
          last_owner_d = grant;
          cnt_d        = CntLoad;
          if (grant == OwnD) begin
            addr_d  = bus.d_addr;
            wr_d    = bus.d_wr;
            wdata_d = bus.d_wdata;
          end else begin
            addr_d  = bus.i_addr;
            wr_d    = 1'b0;
            wdata_d = 16'h0000;
          end
        end
      end
      StBusy: begin
        if (cnt_q == 3'd0) begin
          state_d = StIdle;
          if (owner_q == OwnD) begin
            d_done_d = 1'b1;
            if (!wr_q) d_rdata_d = bus.mem_rdata;
          end else begin
            i_done_d = 1'b1;
            if (!wr_q) i_rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= OwnI;
      last_owner_q <= OwnI;
      cnt_q        <= 3'd0;
      addr_q       <= 16'h0000;
      wr_q         <= 1'b0;
      wdata_q      <= 16'h0000;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      i_rdata_q    <= 16'h0000;
      d_rdata_q    <= 16'h0000;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Memory-side outputs decode purely from state, so reset clears them at once.
  assign bus.busy      = (state_q == StBusy);
  assign bus.mem_en    = bus.busy;
  assign bus.mem_wr    = bus.busy & wr_q & (cnt_q == 3'd0);
  assign bus.mem_addr  = bus.busy ? addr_q : 16'h0000;
  assign bus.mem_wdata = bus.busy ? wdata_q : 16'h0000;
  assign bus.i_done    = i_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_stall   = bus.i_req & ~i_done_q;
  assign bus.d_stall   = bus.d_req & ~d_done_q;

endmodule
